// File: rtl/tile_transpose_pkg.sv
// Shared types and helpers for the tile transpose engine.
// Optional copy mode: TILE_TRANSPOSE_BYPASS_EN.
package tile_transpose_pkg;

   typedef enum logic [1:0] {
      TT_IDLE  = 2'd0,
      TT_READ  = 2'd1,
      TT_DRAIN = 2'd2,
      TT_DONE  = 2'd3
   } tt_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tile_pingpong_buf.sv
// Two DATA_N x DATA_N register tiles: row write port, column read port.
// TILE_TRANSPOSE_BYPASS_EN adds a row-read select for copy mode.
module tile_pingpong_buf
   import tile_transpose_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DATA_N = 8,
   parameter int KW     = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic                     wsel,
   input  logic [KW-1:0]            wrow,
   input  logic [DATA_N*DATA_W-1:0] wdata,
   input  logic                     rsel,
   input  logic [KW-1:0]            ridx,
`ifdef TILE_TRANSPOSE_BYPASS_EN
   input  logic                     rrow,
`endif
   output logic [DATA_N*DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2][DATA_N][DATA_N];
   logic [DATA_W-1:0] mem_d [2][DATA_N][DATA_N];

   always_comb begin
      mem_d = mem_q;
      if (we) begin
         for (int e = 0; e < DATA_N; e++)
            mem_d[wsel][wrow][e] = wdata[e*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int r = 0; r < DATA_N; r++)
               for (int c = 0; c < DATA_N; c++)
                  mem_q[b][r][c] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < DATA_N; i++) begin
         rdata[i*DATA_W +: DATA_W] = mem_q[rsel][i][ridx];
`ifdef TILE_TRANSPOSE_BYPASS_EN
         if (rrow)
            rdata[i*DATA_W +: DATA_W] = mem_q[rsel][ridx][i];
`endif
      end
   end

endmodule

// File: rtl/tile_transpose.sv
// Tiled matrix transpose, source RAM to destination RAM, one word/cycle.
// Optional copy mode via TILE_TRANSPOSE_BYPASS_EN (adds the mode port).
`ifndef N_LEN
`define N_LEN 8
`endif
`ifndef HID_DIM
`define HID_DIM 16
`endif
`ifndef CHAR_NUM
`define CHAR_NUM 16
`endif
module tile_transpose
   import tile_transpose_pkg::*;
#(
   parameter int DATA_W     = `N_LEN,
   parameter int DATA_N     = 8,
   parameter int ROWS       = `HID_DIM,
   parameter int COLS       = `CHAR_NUM,
   parameter int ADDR_WIDTH = 10,
   parameter int RD_LAT     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
`ifdef TILE_TRANSPOSE_BYPASS_EN
   input  logic                     mode,
`endif
   output logic                     busy,
   output logic                     done,
   output logic [ADDR_WIDTH-1:0]    raddr,
   input  logic [DATA_N*DATA_W-1:0] rdata,
   output logic [ADDR_WIDTH-1:0]    waddr,
   output logic [DATA_N*DATA_W-1:0] wdata,
   output logic                     wen
);

   localparam int RW  = ROWS / DATA_N;
   localparam int CW  = COLS / DATA_N;
   localparam int KW  = idx_w(DATA_N);
   localparam int RWW = idx_w(RW);
   localparam int CWW = idx_w(CW);
   localparam logic [KW-1:0]  K_MAX  = KW'(DATA_N - 1);
   localparam logic [RWW-1:0] TR_MAX = RWW'(RW - 1);
   localparam logic [CWW-1:0] TC_MAX = CWW'(CW - 1);
   localparam logic [ADDR_WIDTH-1:0] N_A  = ADDR_WIDTH'(DATA_N);
   localparam logic [ADDR_WIDTH-1:0] RW_A = ADDR_WIDTH'(RW);
   localparam logic [ADDR_WIDTH-1:0] CW_A = ADDR_WIDTH'(CW);

   tt_state_e state_q, state_d;
   logic [KW-1:0]  rk_q, rk_d, wj_q, wj_d;
   logic [RWW-1:0] rtr_q, rtr_d, wtr_q, wtr_d;
   logic [CWW-1:0] rtc_q, rtc_d, wtc_q, wtc_d;
   logic wact_q, wact_d, fsel_q, fsel_d;
   logic          dv_q [RD_LAT];
   logic          dv_d [RD_LAT];
   logic [KW-1:0] dk_q [RD_LAT];
   logic [KW-1:0] dk_d [RD_LAT];
   logic [ADDR_WIDTH-1:0] rhold_q, rhold_d, whold_q, whold_d;
   logic [DATA_N*DATA_W-1:0] dhold_q, dhold_d, col;
   logic [ADDR_WIDTH-1:0] raddr_c, waddr_c;
   logic cap, cap_last;

   // Capture happens RD_LAT cycles after the address was driven.
   assign cap      = dv_q[RD_LAT-1];
   assign cap_last = cap && (dk_q[RD_LAT-1] == K_MAX);

`ifdef TILE_TRANSPOSE_BYPASS_EN
   logic copy_q, copy_d;
   assign copy_d = (state_q == TT_IDLE && start) ? mode : copy_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) copy_q <= 1'b0;
      else        copy_q <= copy_d;
   end
`endif

   tile_pingpong_buf #(
      .DATA_W(DATA_W), .DATA_N(DATA_N), .KW(KW)
   ) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (cap),
      .wsel  (fsel_q),
      .wrow  (dk_q[RD_LAT-1]),
      .wdata (rdata),
      .rsel  (~fsel_q),
      .ridx  (wj_q),
`ifdef TILE_TRANSPOSE_BYPASS_EN
      .rrow  (copy_q),
`endif
      .rdata (col)
   );

   always_comb begin
      raddr_c = (ADDR_WIDTH'(rtr_q) * N_A + ADDR_WIDTH'(rk_q)) * CW_A
              + ADDR_WIDTH'(rtc_q);
      waddr_c = (ADDR_WIDTH'(wtc_q) * N_A + ADDR_WIDTH'(wj_q)) * RW_A
              + ADDR_WIDTH'(wtr_q);
`ifdef TILE_TRANSPOSE_BYPASS_EN
      if (copy_q)
         waddr_c = (ADDR_WIDTH'(wtr_q) * N_A + ADDR_WIDTH'(wj_q)) * CW_A
                 + ADDR_WIDTH'(wtc_q);
`endif
   end

   assign busy    = (state_q == TT_READ) || (state_q == TT_DRAIN);
   assign done    = (state_q == TT_DONE);
   assign raddr   = (state_q == TT_READ) ? raddr_c : rhold_q;
   assign wen     = wact_q & ~abort;
   assign waddr   = wen ? waddr_c : whold_q;
   assign wdata   = wen ? col : dhold_q;
   assign rhold_d = raddr;
   assign whold_d = waddr;
   assign dhold_d = wdata;

   always_comb begin
      state_d = state_q;
      rk_d    = rk_q;
      rtr_d   = rtr_q;
      rtc_d   = rtc_q;
      wj_d    = wj_q;
      wtr_d   = wtr_q;
      wtc_d   = wtc_q;
      wact_d  = wact_q;
      fsel_d  = fsel_q;
      dv_d[0] = (state_q == TT_READ);
      dk_d[0] = rk_q;
      for (int i = 1; i < RD_LAT; i++) begin
         dv_d[i] = dv_q[i-1];
         dk_d[i] = dk_q[i-1];
      end

      unique case (state_q)
         TT_IDLE: if (start) state_d = TT_READ;
         TT_READ: begin
            if (rk_q == K_MAX) begin
               rk_d = '0;
               if (rtr_q == TR_MAX) begin
                  rtr_d = '0;
                  if (rtc_q == TC_MAX) begin
                     rtc_d   = '0;
                     state_d = TT_DRAIN;
                  end else begin
                     rtc_d = rtc_q + 1'b1;
                  end
               end else begin
                  rtr_d = rtr_q + 1'b1;
               end
            end else begin
               rk_d = rk_q + 1'b1;
            end
         end
         TT_DRAIN: begin
            if (wact_q && wj_q == K_MAX && wtr_q == TR_MAX
                && wtc_q == TC_MAX)
               state_d = TT_DONE;
         end
         TT_DONE: state_d = TT_IDLE;
      endcase

      if (wact_q) begin
         if (wj_q == K_MAX) begin
            wj_d   = '0;
            wact_d = 1'b0;
            if (wtr_q == TR_MAX) begin
               wtr_d = '0;
               wtc_d = (wtc_q == TC_MAX) ? '0 : wtc_q + 1'b1;
            end else begin
               wtr_d = wtr_q + 1'b1;
            end
         end else begin
            wj_d = wj_q + 1'b1;
         end
      end

      // Last row landed: swap buffers and start draining that tile.
      if (cap_last) begin
         wact_d = 1'b1;
         fsel_d = ~fsel_q;
      end

      if (abort) begin
         state_d = TT_IDLE;
         rk_d    = '0;
         rtr_d   = '0;
         rtc_d   = '0;
         wj_d    = '0;
         wtr_d   = '0;
         wtc_d   = '0;
         wact_d  = 1'b0;
         fsel_d  = 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            dv_d[i] = 1'b0;
            dk_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= TT_IDLE;
         rk_q    <= '0;
         rtr_q   <= '0;
         rtc_q   <= '0;
         wj_q    <= '0;
         wtr_q   <= '0;
         wtc_q   <= '0;
         wact_q  <= 1'b0;
         fsel_q  <= 1'b0;
         rhold_q <= '0;
         whold_q <= '0;
         dhold_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dv_q[i] <= 1'b0;
            dk_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         rk_q    <= rk_d;
         rtr_q   <= rtr_d;
         rtc_q   <= rtc_d;
         wj_q    <= wj_d;
         wtr_q   <= wtr_d;
         wtc_q   <= wtc_d;
         wact_q  <= wact_d;
         fsel_q  <= fsel_d;
         rhold_q <= rhold_d;
         whold_q <= whold_d;
         dhold_q <= dhold_d;
         for (int i = 0; i < RD_LAT; i++) begin
            dv_q[i] <= dv_d[i];
            dk_q[i] <= dk_d[i];
         end
      end
   end

endmodule

// File: tb/tb_tile_transpose.sv
// Bench: two engines (16x16 lat 2, 24x8 lat 1) against RAM models
// and a flat-index transpose reference.
module tb_tile_transpose;

   logic clk = 1'b0;
   logic rst_n;
   logic start_a, abort_a, start_b, abort_b;
   logic mode_a, mode_b;
   logic busy_a, done_a, wen_a, busy_b, done_b, wen_b;
   logic [9:0] raddr_a, waddr_a, raddr_b, waddr_b;
   logic [63:0] rdata_a, wdata_a, rdata_b, wdata_b;

   logic [63:0] src_a [0:1023];
   logic [63:0] src_b [0:1023];
   logic [63:0] dst_a [0:1023];
   logic [63:0] dst_b [0:1023];
   logic [63:0] expw  [0:1023];
   logic [9:0]  pa [0:2];
   logic [9:0]  pb [0:1];
   logic [9:0]  wseq_b [0:7];

   int cyc = 0;
   int t0_a, t0_b;
   logic clr;
   int wn_a, wf_a, wl_a, dn_a, dc_a, bn_a, bf_a, bl_a;
   int wn_b, dn_b, dc_b;
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tile_transpose #(
      .DATA_W(8), .DATA_N(8), .ROWS(16), .COLS(16),
      .ADDR_WIDTH(10), .RD_LAT(2)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
`ifdef TILE_TRANSPOSE_BYPASS_EN
      .mode(mode_a),
`endif
      .busy(busy_a), .done(done_a), .raddr(raddr_a), .rdata(rdata_a),
      .waddr(waddr_a), .wdata(wdata_a), .wen(wen_a)
   );

   tile_transpose #(
      .DATA_W(8), .DATA_N(8), .ROWS(24), .COLS(8),
      .ADDR_WIDTH(10), .RD_LAT(1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
`ifdef TILE_TRANSPOSE_BYPASS_EN
      .mode(mode_b),
`endif
      .busy(busy_b), .done(done_b), .raddr(raddr_b), .rdata(rdata_b),
      .waddr(waddr_b), .wdata(wdata_b), .wen(wen_b)
   );

   // Source RAMs: data for an address appears RD_LAT cycles later.
   assign rdata_a = src_a[pa[2]];
   assign rdata_b = src_b[pb[1]];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      pa[0] <= raddr_a;
      pa[1] <= pa[0];
      pa[2] <= pa[1];
      pb[0] <= raddr_b;
      pb[1] <= pb[0];
      if (clr) begin
         for (int i = 0; i < 1024; i++) begin
            dst_a[i] <= '0;
            dst_b[i] <= '0;
         end
         wn_a <= 0; wf_a <= -1; wl_a <= -1; dn_a <= 0; dc_a <= -1;
         bn_a <= 0; bf_a <= -1; bl_a <= -1;
         wn_b <= 0; dn_b <= 0; dc_b <= -1;
      end else begin
         if (wen_a) begin
            dst_a[waddr_a] <= wdata_a;
            if (wn_a == 0) wf_a <= cyc - t0_a;
            wl_a <= cyc - t0_a;
            wn_a <= wn_a + 1;
         end
         if (done_a) begin
            dn_a <= dn_a + 1;
            dc_a <= cyc - t0_a;
         end
         if (busy_a) begin
            if (bn_a == 0) bf_a <= cyc - t0_a;
            bl_a <= cyc - t0_a;
            bn_a <= bn_a + 1;
         end
         if (wen_b) begin
            dst_b[waddr_b] <= wdata_b;
            if (wn_b < 8) wseq_b[wn_b] <= waddr_b;
            wn_b <= wn_b + 1;
         end
         if (done_b) begin
            dn_b <= dn_b + 1;
            dc_b <= cyc - t0_b;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   // Destination element (c,r) of the COLS x ROWS result is source (r,c).
   task automatic build_exp(input int sel, input int rows, input int cols);
      for (int w = 0; w < rows * cols / 8; w++) begin
         logic [63:0] v;
         v = '0;
         for (int l = 0; l < 8; l++) begin
            int f, r, c, s;
            f = w * 8 + l;
            c = f / rows;
            r = f % rows;
            s = r * cols + c;
            if (sel == 0) v[l*8 +: 8] = src_a[s/8][(s%8)*8 +: 8];
            else          v[l*8 +: 8] = src_b[s/8][(s%8)*8 +: 8];
         end
         expw[w] = v;
      end
   endtask

   task automatic rand_src_a();
      for (int w = 0; w < 1024; w++) src_a[w] = {$urandom, $urandom};
   endtask

   task automatic wait_done_a(input int budget);
      for (int i = 0; i < budget && dn_a == 0; i++) step();
   endtask

   task automatic run_a_full(input string tag);
      clear();
      t0_a = cyc;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      wait_done_a(200);
      for (int i = 0; i < 10; i++) step();
      build_exp(0, 16, 16);
      for (int w = 0; w < 32; w++)
         chk($sformatf("%s dst[%0d]", tag, w), dst_a[w], expw[w]);
      chk({tag, " done cycle"}, dc_a, 43);
      chk({tag, " wen count"}, wn_a, 32);
   endtask

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; abort_a = 1'b0; mode_a = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; mode_b = 1'b0;
      clr = 1'b1;
      t0_a = 0; t0_b = 0;
      for (int w = 0; w < 1024; w++) begin
         src_a[w] = '0;
         src_b[w] = '0;
      end
      step(); step(); step();

      chk("reset a ctl", {busy_a, done_a, wen_a}, 0);
      chk("reset a addr", {raddr_a, waddr_a}, 0);
      chk("reset a wdata", wdata_a, 0);
      chk("reset b ctl", {busy_b, done_b, wen_b, raddr_b, waddr_b}, 0);
      chk("reset b wdata", wdata_b, 0);
      rst_n = 1'b1;
      step();

      // Counting pattern, with a second start while busy at cycle 5.
      for (int w = 0; w < 32; w++)
         for (int l = 0; l < 8; l++)
            src_a[w][l*8 +: 8] = 8'(w * 8 + l);
      clear();
      t0_a = cyc;
      start_a = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         start_a = (i == 5);
      end
      step();
      start_a = 1'b0;
      wait_done_a(200);
      for (int i = 0; i < 30; i++) step();
      build_exp(0, 16, 16);
      for (int w = 0; w < 32; w++)
         chk($sformatf("ramp dst[%0d]", w), dst_a[w], expw[w]);
      chk("ramp first wen", wf_a, 11);
      chk("ramp last wen", wl_a, 42);
      chk("ramp done cycle", dc_a, 43);
      chk("ramp wen count", wn_a, 32);
      chk("ramp done count", dn_a, 1);
      chk("ramp busy first", bf_a, 1);
      chk("ramp busy last", bl_a, 42);
      chk("ramp busy count", bn_a, 42);

      // Non-square 24x8, latency 1, random data.
      for (int w = 0; w < 1024; w++) src_b[w] = {$urandom, $urandom};
      clear();
      t0_b = cyc;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      for (int i = 0; i < 200 && dn_b == 0; i++) step();
      for (int i = 0; i < 5; i++) step();
      build_exp(1, 24, 8);
      for (int w = 0; w < 24; w++)
         chk($sformatf("b dst[%0d]", w), dst_b[w], expw[w]);
      for (int i = 0; i < 8; i++)
         chk($sformatf("b waddr seq %0d", i), wseq_b[i], i * 3);
      chk("b done cycle", dc_b, 34);
      chk("b wen count", wn_b, 24);
      chk("b done count", dn_b, 1);

      // Abort at cycle 20 during writes.
      rand_src_a();
      clear();
      t0_a = cyc;
      start_a = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         start_a = 1'b0;
      end
      abort_a = 1'b1;
      #1;
      chk("abort wen low", wen_a, 0);
      step();
      abort_a = 1'b0;
      chk("abort busy low", busy_a, 0);
      for (int i = 0; i < 60; i++) step();
      chk("abort no done", dn_a, 0);
      chk("abort wen count", wn_a, 9);
      rand_src_a();
      run_a_full("post-abort");

      // Reset in cycle 15 of a run.
      rand_src_a();
      clear();
      t0_a = cyc;
      start_a = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step();
         start_a = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      chk("mid-rst ctl", {busy_a, done_a, wen_a, raddr_a, waddr_a}, 0);
      chk("mid-rst wdata", wdata_a, 0);
      step(); step();
      chk("mid-rst hold", {busy_a, done_a, wen_a, raddr_a, waddr_a}, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 60; i++) step();
      chk("post-rst wen count", wn_a, 4);
      chk("post-rst no done", dn_a, 0);
      rand_src_a();
      run_a_full("post-rst");

`ifdef TILE_TRANSPOSE_BYPASS_EN
      rand_src_a();
      clear();
      t0_a = cyc;
      mode_a = 1'b1;
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      mode_a = 1'b0;
      wait_done_a(200);
      for (int i = 0; i < 10; i++) step();
      for (int w = 0; w < 32; w++)
         chk($sformatf("copy dst[%0d]", w), dst_a[w], src_a[w]);
      chk("copy done cycle", dc_a, 43);
      chk("copy wen count", wn_a, 32);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tile_transpose.md
Name: tile_transpose

Overview:
Parametrised successor to the dense-layer transpose engine for the training datapath. It reads a ROWS x COLS matrix stored row-major in a source RAM, DATA_N elements per word, and writes its transpose (COLS x ROWS, row-major, DATA_N elements per word) to a destination RAM. It works in DATA_N x DATA_N tiles through a ping-pong tile buffer. Reads and writes overlap, so throughput is one word per cycle. Control is a start/busy/done handshake, with configurable RAM read latency and a synchronous abort.

Parameters:
DATA_W, `N_LEN, element width in bits
DATA_N, 8, elements per RAM word; tile edge length
ROWS, `HID_DIM, source rows; must be a multiple of DATA_N
COLS, `CHAR_NUM, source columns; must be a multiple of DATA_N
ADDR_WIDTH, 10, RAM address width; must satisfy ROWS*COLS/DATA_N <= 2**ADDR_WIDTH
RD_LAT, 2, cycles from raddr driven to rdata valid (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE next cycle
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse after the last write
raddr  out  ADDR_WIDTH  source RAM read address
rdata  in  DATA_N*DATA_W  source word; element e at [e*DATA_W +: DATA_W]
waddr  out  ADDR_WIDTH  destination RAM write address
wdata  out  DATA_N*DATA_W  destination word, same element packing
wen  out  1  destination write strobe

Behaviour:
- Reset: all outputs are 0. FSM is in IDLE. Both tile buffers and all counters are cleared.
- Derived constants: RW = ROWS/DATA_N, CW = COLS/DATA_N, T = RW*CW tiles.
- Tile order: tc outer, 0..CW-1; tr inner, 0..RW-1.
- Reads for tile (tr,tc), k = 0..DATA_N-1: raddr = (tr*DATA_N+k)*CW + tc. One address per cycle, with no gap between tiles.
- Capture: the word read with index k is stored in tile row k of the fill buffer. The capture index travels through a RD_LAT-deep delay line.
- Writes for tile (tr,tc), j = 0..DATA_N-1: waddr = (tc*DATA_N+j)*RW + tr.
- Write data: element i of wdata equals tile[i][j], i.e. source element (tr*DATA_N+i, tc*DATA_N+j).
- Buffer swap: buffers swap when the last word of a tile is captured. A tile is written over the DATA_N cycles after its fill completes, while the next tile fills the other buffer.
- Timing (start sampled in cycle 0): first raddr in cycle 1. Tile t is written in cycles t*DATA_N+DATA_N+RD_LAT+1 .. (t+1)*DATA_N+DATA_N+RD_LAT. done pulses in cycle T*DATA_N+DATA_N+RD_LAT+1, and busy falls in the same cycle.
- FSM states:
  - IDLE: start moves to READ.
  - READ: issues T*DATA_N reads, then moves to DRAIN.
  - DRAIN: waits for the final capture and write, then moves to DONE.
  - DONE: asserts done for one cycle, then moves to IDLE.
- Outside READ, raddr holds its last value. Outside write cycles, wen=0 and waddr/wdata hold their last values.
- start while busy is ignored.
- abort in any state: IDLE on the next edge. wen is forced to 0 in that same cycle, no done is produced, and buffer contents are don't-care.
- abort and start in the same cycle: abort wins.
- Reset mid-operation clears everything immediately. No partial writes occur after rst_n deasserts.
- Counters wrap exactly at RW, CW and DATA_N. Address arithmetic is done at ADDR_WIDTH with no overflow, given the parameter constraint.

Optional Feature:
TILE_TRANSPOSE_BYPASS_EN
- With the macro defined: an extra input port mode (1 bit) is sampled at start.
- mode=1 is copy mode, with the same timing, tile order and handshake. waddr equals the read address of the same word, and wdata equals that rdata word unpermuted.
- mode=0 is the transpose described above.
- Without the macro: no mode port; transpose only. The bypass mux is not synthesised.

Decomposition:
- Shared header consts_train.vh: `N_LEN, `HID_DIM, `CHAR_NUM, and the FSM state encodings TT_IDLE/TT_READ/TT_DRAIN/TT_DONE.
- One sub-module, tile_pingpong_buf: two DATA_N x DATA_N register tiles. It provides a write-row port (row index, data, select) and a transposed column read port (column index, select).
- Top level holds the FSM, the address counters and the latency delay lines.

Test Plan:
- DATA_N=8, ROWS=COLS=16, RD_LAT=2, source element (r,c)=r*16+c; pulse start -> destination element (c,r)=r*16+c for all 256 elements. First wen in cycle 11, last wen in cycle 42, done in cycle 43, busy high in cycles 1..42.
- DATA_N=8, ROWS=24, COLS=8, RD_LAT=1 (non-square) -> waddr sequence 0,3,6,9,12,15,18,21 then 1,4,7,... Output is 8x24 transposed; done in cycle 3*8+8+1+1=34.
- start pulsed again while busy (cycle 5) -> ignored; exactly 32 wen and exactly one done.
- abort at cycle 20 -> wen=0 from cycle 20, busy=0 at cycle 21, no done. A fresh start then gives a full correct transpose.
- rst_n low at cycle 15 -> all outputs 0 while asserted and no wen afterwards until a new start.
- With TILE_TRANSPOSE_BYPASS_EN and mode=1 -> destination equals source word-for-word, with the same done cycle as transpose mode.
